// File: rtl/dip_debounce_if.sv
// Switch-bank bus between the raw DIP inputs and the debounced consumer side.
// The slave modport belongs to the debouncer; the master drives dip and observes the results.
interface dip_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dip;
  logic [WIDTH-1:0] dip_out;
  logic             dip_chg;
  logic             busy;

  modport master (
    output dip,
    input  dip_out,
    input  dip_chg,
    input  busy
  );

  modport slave (
    input  dip,
    output dip_out,
    output dip_chg,
    output busy
  );
endinterface

// File: rtl/dip_debounce.sv
// Whole-vector DIP switch debouncer: 2-flop synchroniser followed by a settle FSM that
// commits a new vector only after it has held for STABLE_CYCLES clocks.
module dip_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = 20
) (
  input  logic           clk_50Mhz,
  input  logic           rst,
  dip_debounce_if.slave  bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dip_out_q, dip_out_d;
  logic             dip_chg_q, dip_chg_d;

  always_comb begin
    sync1_d = bus.dip;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      dip_out_q <= '0;
      dip_chg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      dip_out_q <= dip_out_d;
      dip_chg_q <= dip_chg_d;
    end
  end

  // Any bit moving restarts the count for the whole vector; bits never commit individually.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    dip_out_d = dip_out_q;
    dip_chg_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync2_q != dip_out_q) begin
          state_d = SETTLE;
          cand_d  = sync2_q;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (sync2_q == dip_out_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sync2_q != cand_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          dip_out_d = cand_q;
          dip_chg_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dip_out = dip_out_q;
  assign bus.dip_chg = dip_chg_q;
  assign bus.busy    = (state_q == SETTLE);

endmodule
